// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte streams.
// Grants are held per burst (up to MAX_BURST bytes or the requester's last byte), then rotated.
module uart_tx_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8,
    parameter int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic [IDW-1:0]         grant_id,
    output logic                   active
);

    // state | meaning
    // IDLE  | no grant held; pick the next valid requester after last_grant
    // SEND  | grant held; accept one byte when the transmitter is free
    // WAIT  | byte launched; wait for the transmitter's end-of-frame pulse
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    localparam int BCW = $clog2(MAX_BURST + 1);

    state_t           state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   next_id;
    logic [IDW-1:0]   cand;
    logic             any_valid;
    logic [BCW-1:0]   burst_cnt;
    logic             last_flag;

    // Descending scan so the candidate closest after last_grant wins.
    always_comb begin
        any_valid = 1'b0;
        next_id   = last_grant;
        cand      = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDW'((int'(last_grant) + i) % NUM_REQ);
            if (req_valid[cand]) begin
                any_valid = 1'b1;
                next_id   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == SEND && !tx_busy)
            req_ready[grant_id] = 1'b1;
    end

    assign active = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            grant_id   <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
            burst_cnt  <= '0;
            last_flag  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id  <= next_id;
                        burst_cnt <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    // A stalled requester loses the grant rather than blocking the others.
                    if (!req_valid[grant_id]) begin
                        last_grant <= grant_id;
                        state      <= IDLE;
                    end else if (!tx_busy) begin
                        tx_data   <= req_data[{grant_id, 3'b000} +: 8];
                        tx_start  <= 1'b1;
                        last_flag <= req_last[grant_id];
                        burst_cnt <= burst_cnt + BCW'(1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (tx_done) begin
                        if (last_flag || burst_cnt == BCW'(MAX_BURST)) begin
                            last_grant <= grant_id;
                            state      <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: requesters and transmitter are emulated in one initial block.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        active;

    int          checks = 0;
    int          errors = 0;

    int          remaining [4];
    bit          last_each [4];
    bit          hold      [4];
    int          sent      [4];
    logic [7:0]  base      [4];

    uart_tx_scheduler #(.NUM_REQ(4), .MAX_BURST(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .grant_id  (grant_id),
        .active    (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester i offers base[i]+sent[i]; last is set on every byte or only the final one.
    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (remaining[i] > 0) && !hold[i];
            req_data[8*i +: 8] = base[i] + 8'(sent[i]);
            req_last[i]        = last_each[i] || (remaining[i] == 1);
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < 4; i++) begin
            remaining[i] = 0;
            last_each[i] = 1'b0;
            hold[i]      = 1'b0;
            sent[i]      = 0;
        end
        refresh();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        clear_reqs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Waits for the launch of requester id's next byte, then plays one frame and its tx_done pulse.
    // lat is the number of falling edges from the call until tx_start is seen.
    task automatic xmit(input int id, output int lat);
        bit found;
        found = 1'b0;
        lat   = 0;
        for (int c = 1; c <= 100 && !found; c++) begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                found = 1'b1;
                lat   = c;
            end
        end
        chk("tx_start_seen", 32'(found), 32'd1);
        if (found) begin
            chk("tx_data", 32'(tx_data), 32'(base[id] + 8'(sent[id])));
            chk("grant_id_frame", 32'(grant_id), 32'(id));
            sent[id]++;
            remaining[id]--;
            refresh();
            tx_busy = 1'b1;
            @(negedge clk);
            chk("tx_start_single", 32'(tx_start), 32'd0);
            repeat (2) @(negedge clk);
            tx_busy = 1'b0;
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    endtask

    initial begin
        int  lat;
        bit  bad;

        base[0] = 8'h3C;
        base[1] = 8'h51;
        base[2] = 8'hA5;
        base[3] = 8'hE7;
        rst     = 1'b0;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        clear_reqs();

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;

        // Single request from requester 2
        remaining[2] = 1;
        last_each[2] = 1'b1;
        refresh();
        @(negedge clk);
        chk("single_active", 32'(active), 32'd1);
        chk("single_ready", 32'(req_ready), 32'b0100);
        chk("single_grant", 32'(grant_id), 32'd2);
        xmit(2, lat);
        chk("single_latency", 32'(lat), 32'd1);
        chk("single_idle", 32'(active), 32'd0);
        chk("single_grant_kept", 32'(grant_id), 32'd2);
        chk("single_ready_idle", 32'(req_ready), 32'd0);

        // Round robin: one last byte per grant, order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            remaining[i] = 2;
            last_each[i] = 1'b1;
        end
        refresh();
        xmit(0, lat);
        chk("rr_first_latency", 32'(lat), 32'd2);
        xmit(1, lat);
        chk("rr_release_latency", 32'(lat), 32'd2);
        xmit(2, lat);
        xmit(3, lat);
        xmit(0, lat);

        // Burst cap: 8 bytes from requester 1, then 1 from requester 3, then requester 1 again
        do_reset();
        remaining[1] = 20;
        remaining[3] = 1;
        last_each[3] = 1'b1;
        refresh();
        xmit(1, lat);
        for (int b = 1; b < 8; b++) begin
            xmit(1, lat);
            chk("burst_cont_latency", 32'(lat), 32'd1);
        end
        xmit(3, lat);
        chk("burst_rotate_latency", 32'(lat), 32'd2);
        xmit(1, lat);

        // Backpressure: tx_busy high for 50 cycles while in SEND
        do_reset();
        tx_busy      = 1'b1;
        remaining[0] = 1;
        last_each[0] = 1'b1;
        refresh();
        bad = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_ready !== 4'b0000 || tx_start !== 1'b0 || active !== 1'b1)
                bad = 1'b1;
        end
        chk("backpressure_hold", 32'(bad), 32'd0);
        tx_busy = 1'b0;
        #1;
        chk("backpressure_ready", 32'(req_ready), 32'b0001);
        xmit(0, lat);
        chk("backpressure_latency", 32'(lat), 32'd1);

        // Stall release: requester 0 drops valid after 3 of 5 bytes
        do_reset();
        remaining[0] = 5;
        remaining[1] = 1;
        last_each[1] = 1'b1;
        refresh();
        xmit(0, lat);
        xmit(0, lat);
        xmit(0, lat);
        hold[0] = 1'b1;
        refresh();
        @(negedge clk);
        chk("stall_released", 32'(active), 32'd0);
        @(negedge clk);
        chk("stall_regrant_active", 32'(active), 32'd1);
        chk("stall_regrant_id", 32'(grant_id), 32'd1);
        hold[0] = 1'b0;
        refresh();
        xmit(1, lat);
        chk("stall_req1_latency", 32'(lat), 32'd1);
        xmit(0, lat);
        chk("stall_req0_return_latency", 32'(lat), 32'd2);

        // Reset asserted while in WAIT
        do_reset();
        remaining[2] = 1;
        last_each[2] = 1'b1;
        refresh();
        bad = 1'b1;
        for (int c = 0; c < 20 && bad; c++) begin
            @(negedge clk);
            if (tx_start === 1'b1) bad = 1'b0;
        end
        chk("midreset_launch_seen", 32'(bad), 32'd0);
        tx_busy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_active", 32'(active), 32'd0);
        chk("midreset_grant_id", 32'(grant_id), 32'd0);
        chk("midreset_tx_data", 32'(tx_data), 32'd0);
        chk("midreset_tx_start", 32'(tx_start), 32'd0);
        chk("midreset_req_ready", 32'(req_ready), 32'd0);
        tx_busy = 1'b0;
        clear_reqs();
        remaining[0] = 1;
        last_each[0] = 1'b1;
        remaining[2] = 1;
        last_each[2] = 1'b1;
        refresh();
        @(negedge clk);
        rst = 1'b1;
        xmit(0, lat);
        xmit(2, lat);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares a single UART transmitter among NUM_REQ byte-stream requesters. It accepts bytes over per-requester valid/ready ports and launches each byte into the transmitter with a one-cycle start pulse. It waits for the transmitter's end-of-frame pulse before issuing the next byte. Grants are held per burst, up to MAX_BURST bytes or until the requester's last byte, then rotated. It sits between the firmware/DMA byte sources and the UART transmitter FSM.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_BURST, 8: maximum bytes sent per grant before forced rotation, 1..15.
- IDW, $clog2(NUM_REQ): width of grant_id.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  byte offered by requester i.
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte of requester i is the last byte of its burst.
- req_ready  out  NUM_REQ  byte of requester i accepted this cycle; one-hot or zero.
- tx_start  out  1  one-cycle pulse that launches a frame in the transmitter.
- tx_data  out  8  byte for the transmitter; valid while tx_start is high and held until the next launch.
- tx_busy  in  1  transmitter is framing a byte.
- tx_done  in  1  one-cycle pulse at the end of the transmitter's stop bit.
- grant_id  out  IDW  index of the current or most recent grant holder.
- active  out  1  a grant is held (state not IDLE).

## Operation
- The FSM has three states: IDLE, SEND and WAIT. After reset it is in IDLE.
- Reset values:
  - tx_start=0, tx_data=0, req_ready=0, grant_id=0, active=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - burst_cnt=0.
- IDLE:
  - If any req_valid is high, grant the first requester with req_valid high, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - Register grant_id, clear burst_cnt, and move to SEND.
- SEND:
  - req_ready[grant_id] = !tx_busy. This is combinational on state and tx_busy. All other req_ready bits are 0.
  - Handshake fires when req_valid[g] and req_ready[g] are both high. On the firing edge:
    - tx_data <= req_data[g]
    - tx_start <= 1 for exactly one cycle
    - latch last_flag <= req_last[g]
    - burst_cnt += 1
    - move to WAIT
  - If req_valid[g] is low (requester stalled mid-burst): release the grant, set last_grant <= g, and go to IDLE. The grant is not held for stalled requesters.
  - If tx_busy is high: stay in SEND with req_ready=0.
- WAIT:
  - Wait for tx_done. tx_done in IDLE or SEND is ignored.
  - On tx_done, if last_flag is set or burst_cnt == MAX_BURST: set last_grant <= g and go to IDLE.
  - Otherwise, return to SEND with the same grantee.
- burst_cnt is $clog2(MAX_BURST+1) bits wide and never exceeds MAX_BURST.
- grant_id keeps its value in IDLE until the next grant.
- The transmitter is never started while tx_busy is high or before the previous tx_done.
- Asynchronous reset asserted mid-frame forces all reset values immediately. A byte in flight is abandoned and never re-requested.

## Timing
- Cycle 0: req_valid seen in IDLE.
- Cycle 1: SEND, active=1, req_ready[g]=1 (if !tx_busy).
- Cycle 2: tx_start=1 with tx_data, state WAIT.
- Minimum latency from request to tx_start is 2 cycles.
- tx_done in cycle k leads to:
  - Burst continues: SEND in k+1, next tx_start in k+2.
  - Burst ends: IDLE in k+1, SEND for the new grant in k+2, tx_start in k+3.
- Simultaneous events:
  - tx_done arriving with a new req_valid from another requester: the current burst rules take precedence. Rotation happens only on release.
  - req_valid deasserted in the same cycle req_ready is high: no handshake; release per the SEND rule.
- Exactly one tx_start per accepted byte, and exactly one accepted byte per tx_done.

## Test plan
- Single request after reset: req_valid[2]=1, data 0xA5, last=1, transmitter idle.
  - Required: req_ready[2] high in cycle 1, tx_start with tx_data=0xA5 in cycle 2.
  - After tx_done: active=0, grant_id=2.
- Round-robin: all four requesters each offer one last=1 byte continuously.
  - Required: bytes leave in order 0,1,2,3,0 and grant_id follows the same sequence.
- Burst cap with MAX_BURST=8: requester 1 streams 20 bytes with last=0 while requester 3 is also valid.
  - Required: bytes sent as 8 from requester 1, 1 from requester 3, then requester 1 resumes.
- Backpressure: tx_busy held high for 50 cycles while in SEND.
  - Required: req_ready=0 and no tx_start for those 50 cycles.
  - Handshake fires on the first cycle tx_busy is low.
- Stall release: requester 0 drops req_valid after 3 of 5 bytes while requester 1 is valid.
  - Required: requester 1 is granted the cycle after the stall is detected.
  - Requester 0 regains the grant only after requester 1 releases.
- Reset mid-frame: assert rst while in WAIT.
  - Required: all outputs return to reset values immediately.
  - After release, the first grant goes to requester 0 if it is valid.
